// File: rtl/dvsd_adder_pkg.sv
// Shared constants and helpers for the carry-pipelined adder/subtractor.
package dvsd_adder_pkg;

    localparam int DEF_WIDTH = 12;
    localparam int DEF_BLK   = 4;

    // Number of CLA slices, which is also the number of pipeline stages.
    function automatic int calc_nst(input int width, input int blk);
        return width / blk;
    endfunction

    // Index of the least-significant bit handled by slice k.
    function automatic int slice_lo(input int k, input int blk);
        return k * blk;
    endfunction

endpackage

// File: rtl/dvsd_cla_blk.sv
// Combinational BLK-bit carry-lookahead slice. c_msb is the carry into the
// slice MSB, used for the signed-overflow flag on the top slice.
module dvsd_cla_blk
    import dvsd_adder_pkg::*;
#(
    parameter int BLK = DEF_BLK
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           ci,
    output logic [BLK-1:0] s,
    output logic           co,
    output logic           c_msb
);

    logic [BLK-1:0] p;
    logic [BLK-1:0] g;
    logic [BLK:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry is the flat lookahead sum-of-products of generates and
    // propagates, so no carry depends on a neighbouring carry.
    always_comb begin
        logic term;
        c = '0;
        c[0] = ci;
        for (int i = 0; i < BLK; i++) begin
            term = ci;
            for (int j = 0; j <= i; j++) term = term & p[j];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
    end

    assign s     = p ^ c[BLK-1:0];
    assign co    = c[BLK];
    assign c_msb = c[BLK-1];

endmodule

// File: rtl/dvsd_adder_pipe.sv
// Carry-pipelined adder/subtractor: one BLK-bit CLA slice per stage, carry
// registered between stages, latency NST cycles.
// Optional macro DVSD_ADDER_PIPE_OVF_EN adds the OVF signed-overflow output.
//
// Handshake: a beat enters when in_valid & in_ready on a rising edge; a result
// leaves when out_valid & out_ready & CE on a rising edge. in_ready is the
// global advance CE & (~out_valid | out_ready), so CE=0 freezes both sides and
// a stalled output holds S/Cout/out_valid and blocks every upstream stage.
module dvsd_adder_pipe
    import dvsd_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLK   = DEF_BLK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CE,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef DVSD_ADDER_PIPE_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int NST = calc_nst(WIDTH, BLK);

    logic adv;

    assign adv      = CE & (~out_valid | out_ready);
    assign in_ready = adv;

    genvar k;
    generate
        for (k = 0; k < NST; k++) begin : stg
            localparam int LO = slice_lo(k, BLK);

            // Stage inputs: raw operands for stage 0, previous stage otherwise.
            logic [WIDTH-1:0] a_in;
            logic [WIDTH-1:0] b_in;
            logic [WIDTH-1:0] s_in;
            logic             c_in;
            logic             v_in;

            // Stage registers: skewed operands, partial result, carry, valid.
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] s_q;
            logic             c_q;
            logic             v_q;

            logic [BLK-1:0]   sl_s;
            logic             sl_co;
            logic             sl_cm;
            logic [WIDTH-1:0] s_nxt;

            if (k == 0) begin : g_first
                // Subtraction inverts B and forces the carry-in to 1.
                assign a_in = A;
                assign b_in = B ^ {WIDTH{sub}};
                assign c_in = sub | Cin;
                assign s_in = '0;
                assign v_in = in_valid;
            end else begin : g_next
                assign a_in = stg[k-1].a_q;
                assign b_in = stg[k-1].b_q;
                assign c_in = stg[k-1].c_q;
                assign s_in = stg[k-1].s_q;
                assign v_in = stg[k-1].v_q;
            end

            dvsd_cla_blk #(
                .BLK (BLK)
            ) u_cla (
                .a     (a_in[LO +: BLK]),
                .b     (b_in[LO +: BLK]),
                .ci    (c_in),
                .s     (sl_s),
                .co    (sl_co),
                .c_msb (sl_cm)
            );

            // Merge this slice's sum bits into the delay-aligned result word.
            always_comb begin
                s_nxt = s_in;
                s_nxt[LO +: BLK] = sl_s;
            end

            // Stage register: shifts on advance, flushed by reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (adv) begin
                    a_q <= a_in;
                    b_q <= b_in;
                    s_q <= s_nxt;
                    c_q <= sl_co;
                    v_q <= v_in;
                end
            end

`ifdef DVSD_ADDER_PIPE_OVF_EN
            logic o_q;

            // Overflow of this slice travels with the result; only the top
            // slice's value reaches the OVF port.
            always_ff @(posedge clk) begin
                if (rst) begin
                    o_q <= 1'b0;
                end else if (adv) begin
                    o_q <= sl_cm ^ sl_co;
                end
            end
`else
            logic unused_cm;
            assign unused_cm = sl_cm;
`endif
            // Operand bits already consumed by earlier slices are dead here.
            logic unused_ops;
            assign unused_ops = ^{a_q, b_q};
        end
    endgenerate

    assign out_valid = stg[NST-1].v_q;
    assign S         = stg[NST-1].s_q;
    assign Cout      = stg[NST-1].c_q;
`ifdef DVSD_ADDER_PIPE_OVF_EN
    assign OVF       = stg[NST-1].o_q;
`endif

endmodule
